// File: rtl/flag_register_unit_pkg.sv
// Shared definitions for the EX-stage condition-flag unit: widths, opcodes,
// flag bit positions and FSM encoding.
package flag_register_unit_pkg;
  localparam int DW     = 16;
  localparam int NFLAGS = 3;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_B      = 4'b1100;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_PCS    = 4'b1110;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fsm_state_t;
endpackage

// File: rtl/flag_register_unit_if.sv
// EX-stage to flag-unit bundle. ex_valid qualifies the EX fields in the cycle it
// is high; stall/flush gate it. There is no back-pressure: the unit always accepts.
interface flag_register_unit_if;
  import flag_register_unit_pkg::*;

  logic              ex_valid;
  logic [3:0]        ex_opcode;
  logic [DW-1:0]     alu_result;
  logic              alu_ovfl;
  logic              stall;
  logic              flush;
  logic [NFLAGS-1:0] flags_q;
  logic [NFLAGS-1:0] flags_fwd;
  logic              flags_wr;
  logic              halted;
  logic [15:0]       flag_wr_cnt;
  fsm_state_t        dbg_state;

  modport master (
    output ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush,
    input  flags_q, flags_fwd, flags_wr, halted, flag_wr_cnt, dbg_state
  );

  modport slave (
    input  ex_valid, ex_opcode, alu_result, alu_ovfl, stall, flush,
    output flags_q, flags_fwd, flags_wr, halted, flag_wr_cnt, dbg_state
  );
endinterface

// File: rtl/flag_register_unit_flag_eval.sv
// Combinational decode of which flags an opcode may write, and the candidate
// {Z,V,N} values computed from the ALU outputs.
module flag_eval
  import flag_register_unit_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic [DW-1:0]     alu_result,
  input  logic              alu_ovfl,
  output logic [NFLAGS-1:0] mask,
  output logic [NFLAGS-1:0] new_flags
);
  always_comb begin
    mask = '0;
    case (opcode)
      OP_ADD, OP_SUB:                 mask = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask[FLAG_Z] = 1'b1;
      default:                        mask = '0;
    endcase
  end

  always_comb begin
    new_flags         = '0;
    new_flags[FLAG_Z] = (alu_result == '0);
    new_flags[FLAG_V] = alu_ovfl;
    new_flags[FLAG_N] = alu_result[DW-1];
  end
endmodule

// File: rtl/flag_register_unit.sv
// Architectural {Z,V,N} register with same-cycle forwarding, change pulse,
// commit counter and a RUN/HALTED FSM that only reset can leave.
module flag_register_unit
  import flag_register_unit_pkg::*;
(
  input logic                clk,
  input logic                rst,
  flag_register_unit_if.slave bus
);
  logic [NFLAGS-1:0] mask;
  logic [NFLAGS-1:0] new_flags;
  logic [NFLAGS-1:0] flags_r;
  logic [NFLAGS-1:0] next_flags;
  logic [15:0]       cnt_r;
  logic              wr_r;
  fsm_state_t        state;
  logic              live;
  logic              commit;

  flag_eval u_eval (
    .opcode     (bus.ex_opcode),
    .alu_result (bus.alu_result),
    .alu_ovfl   (bus.alu_ovfl),
    .mask       (mask),
    .new_flags  (new_flags)
  );

  // An instruction that survives stall/flush while running; both commits and HLT need it.
  assign live       = bus.ex_valid & ~bus.stall & ~bus.flush & (state == RUN);
  assign commit     = live & (mask != '0);
  assign next_flags = (flags_r & ~mask) | (new_flags & mask);

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= '0;
      cnt_r   <= '0;
      wr_r    <= 1'b0;
      state   <= RUN;
    end else begin
      wr_r <= commit && (next_flags != flags_r);
      if (commit) begin
        flags_r <= next_flags;
        cnt_r   <= cnt_r + 16'd1;
      end
      case (state)
        RUN:     if (live && bus.ex_opcode == OP_HLT) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  assign bus.flags_q     = flags_r;
  assign bus.flags_fwd   = commit ? next_flags : flags_r;
  assign bus.flags_wr    = wr_r;
  assign bus.halted      = (state == HALTED);
  assign bus.flag_wr_cnt = cnt_r;
  assign bus.dbg_state   = state;
endmodule

// File: tb/tb_flag_register_unit.sv
// Bench for flag_register_unit: directed scenarios plus randomized traffic,
// scored against a per-flag behavioural model.
module tb_flag_register_unit;
  logic clk;
  logic rst;

  flag_register_unit_if bus();

  flag_register_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  logic [2:0]  m_flags;
  logic [15:0] m_cnt;
  logic        m_halted;
  logic        m_wr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Which flags (Z,V,N order) an opcode is allowed to write.
  function automatic logic [2:0] writable(input logic [3:0] op);
    if (op == 4'd0 || op == 4'd1) return 3'b111;
    if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) return 3'b100;
    return 3'b000;
  endfunction

  task automatic model_reset();
    m_flags  = 3'b000;
    m_cnt    = 16'd0;
    m_halted = 1'b0;
    m_wr     = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [3:0] op, input logic [15:0] res,
                      input logic ov, input logic st, input logic fl, input logic chk);
    logic [2:0] w;
    logic [2:0] vals;
    logic [2:0] nxt;
    logic live;
    logic writes;
    @(negedge clk);
    rst = 1'b0;
    bus.ex_valid = v; bus.ex_opcode = op; bus.alu_result = res;
    bus.alu_ovfl = ov; bus.stall = st; bus.flush = fl;
    live   = v && !st && !fl && !m_halted;
    w      = writable(op);
    writes = live && (w != 3'b000);
    vals   = {res == 16'd0, ov, res[15]};
    for (int i = 0; i < 3; i++) nxt[i] = (writes && w[i]) ? vals[i] : m_flags[i];
    #1;
    if (chk) check("flags_fwd", bus.flags_fwd, nxt);
    @(posedge clk);
    m_wr    = writes && (nxt != m_flags);
    m_flags = nxt;
    if (writes) m_cnt = m_cnt + 16'd1;
    if (live && op == 4'hF) m_halted = 1'b1;
    exp_q.push_back(m_flags);
    #1;
    if (chk) begin
      check("flags_q", bus.flags_q, exp_q.pop_front());
      check("flags_wr", bus.flags_wr, m_wr);
      check("halted", bus.halted, m_halted);
      check("flag_wr_cnt", bus.flag_wr_cnt, m_cnt);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  // Reset with a flag-writing ADD presented on the same edge; reset must win.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_opcode = 4'h0; bus.alu_result = 16'h0000;
    bus.alu_ovfl = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    check("rst_flags_q", bus.flags_q, m_flags);
    check("rst_flags_wr", bus.flags_wr, 1'b0);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_cnt", bus.flag_wr_cnt, m_cnt);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.ex_valid = 1'b0; bus.ex_opcode = 4'h0; bus.alu_result = 16'h0;
    bus.alu_ovfl = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    model_reset();
    do_reset();

    // 1: ADD zero result sets Z alone
    step(1, 4'h0, 16'h0000, 0, 0, 0, 1);
    check("t1_flags_q", bus.flags_q, 3'b100);
    check("t1_wr", bus.flags_wr, 1'b1);
    check("t1_cnt", bus.flag_wr_cnt, 16'd1);

    // 2: SUB negative+overflow, then XOR touches Z only
    do_reset();
    step(1, 4'h1, 16'h8000, 1, 0, 0, 1);
    check("t2_sub", bus.flags_q, 3'b011);
    step(1, 4'h2, 16'h0001, 0, 0, 0, 1);
    check("t2_xor", bus.flags_q, 3'b011);
    check("t2_wr", bus.flags_wr, 1'b0);
    check("t2_cnt", bus.flag_wr_cnt, 16'd2);

    // 3: stall, flush, then release
    step(1, 4'h0, 16'h0000, 0, 1, 0, 1);
    check("t3_stall", bus.flags_q, 3'b011);
    step(1, 4'h0, 16'h0000, 0, 0, 1, 1);
    step(1, 4'h0, 16'h0000, 0, 1, 1, 1);
    check("t3_flush_cnt", bus.flag_wr_cnt, 16'd2);
    step(1, 4'h0, 16'h0000, 0, 0, 0, 1);
    check("t3_release", bus.flags_q, 3'b100);

    // 4: non-flag opcodes and invalid slots
    step(1, 4'h8, 16'h0000, 1, 0, 0, 1);
    step(1, 4'h7, 16'h0000, 1, 0, 0, 1);
    step(1, 4'hC, 16'h8000, 1, 0, 0, 1);
    step(0, 4'h1, 16'h8000, 1, 0, 0, 1);
    check("t4_flags", bus.flags_q, 3'b100);
    check("t4_cnt", bus.flag_wr_cnt, 16'd3);

    // 5: HLT freezes the unit until reset
    step(1, 4'hF, 16'h1234, 0, 1, 0, 1);
    check("t5_stalled_hlt", bus.halted, 1'b0);
    step(1, 4'hF, 16'h1234, 0, 0, 0, 1);
    check("t5_halted", bus.halted, 1'b1);
    step(1, 4'h1, 16'h8000, 1, 0, 0, 1);
    check("t5_frozen", bus.flags_q, 3'b100);
    do_reset();
    check("t5_unhalt", bus.halted, 1'b0);

    // randomized traffic, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if (m_halted && $urandom_range(0, 7) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), r,
                1'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, 1);
    end

    // 6: counter wrap across 65536 commits
    do_reset();
    for (int n = 0; n < 65535; n++)
      step(1, 4'($urandom_range(0, 1)), 16'($urandom), 1'($urandom), 0, 0, 0);
    #1;
    check("t6_cnt_ffff", bus.flag_wr_cnt, 16'hFFFF);
    step(1, 4'h2, 16'h0000, 0, 0, 0, 1);
    check("t6_wrap", bus.flag_wr_cnt, 16'h0000);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
